// File: rtl/led_bar_pkg.sv
// Shared types and constants for the 16-LED thermometer bar sequencer.
// Saturating step helpers treat any out-of-range level (17..31) as 16.
package led_bar_pkg;

  typedef enum logic [1:0] {
    MANUAL     = 2'd0,
    SWEEP_UP   = 2'd1,
    SWEEP_DOWN = 2'd2
  } led_bar_state_t;

  localparam logic [4:0] LED_BAR_MAX = 5'd16;
  localparam logic [4:0] LED_BAR_MIN = 5'd0;

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v >= LED_BAR_MAX) ? LED_BAR_MAX : v + 5'd1;
  endfunction

  function automatic logic [4:0] sat_dec(input logic [4:0] v);
    if (v > LED_BAR_MAX) return LED_BAR_MAX - 5'd1;
    if (v == LED_BAR_MIN) return LED_BAR_MIN;
    return v - 5'd1;
  endfunction

endpackage

// File: rtl/led_bar_controller_tick_gen.sv
// Sweep prescaler: pulses tick once every TICK_DIV enabled cycles.
// The counter is held cleared while enable is low.
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!enable || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/led_bar_controller.sv
// LED bar level sequencer: manual up/down stepping or automatic 0..16 ping-pong sweep.
// Define LED_BAR_BTN_SYNC_EN to pass buttons through a 2-flop synchronizer and rising-edge detector.
module led_bar_controller
  import led_bar_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       auto_en,
  output logic [4:0] current_count,
  output logic       at_max,
  output logic       at_min,
  output logic       sweep_dir
);

  logic up_evt;
  logic down_evt;

`ifdef LED_BAR_BTN_SYNC_EN
  logic [1:0] up_sync;
  logic [1:0] down_sync;
  logic       up_prev;
  logic       down_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_sync   <= 2'b00;
      down_sync <= 2'b00;
      up_prev   <= 1'b0;
      down_prev <= 1'b0;
    end else begin
      up_sync   <= {up_sync[0], btn_up};
      down_sync <= {down_sync[0], btn_down};
      up_prev   <= up_sync[1];
      down_prev <= down_sync[1];
    end
  end

  assign up_evt   = up_sync[1] & ~up_prev;
  assign down_evt = down_sync[1] & ~down_prev;
`else
  assign up_evt   = btn_up;
  assign down_evt = btn_down;
`endif

  led_bar_state_t state;
  led_bar_state_t state_next;
  logic [4:0]     count;
  logic [4:0]     count_next;
  logic           tick;
  logic           sweep_active;

  // Gating with auto_en clears the prescaler on the exit edge and suppresses a coincident tick.
  assign sweep_active = (state != MANUAL) && auto_en;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (sweep_active),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MANUAL;
      count <= LED_BAR_MIN;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Buttons are only honoured in MANUAL while auto_en is low, so the entry edge never steps.
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      MANUAL: begin
        if (auto_en) begin
          state_next = (count >= LED_BAR_MAX) ? SWEEP_DOWN : SWEEP_UP;
        end else if (up_evt && !down_evt) begin
          count_next = sat_inc(count);
        end else if (down_evt && !up_evt) begin
          count_next = sat_dec(count);
        end
      end
      SWEEP_UP: begin
        if (!auto_en) begin
          state_next = MANUAL;
        end else if (tick) begin
          count_next = sat_inc(count);
          if (count_next == LED_BAR_MAX) state_next = SWEEP_DOWN;
        end
      end
      SWEEP_DOWN: begin
        if (!auto_en) begin
          state_next = MANUAL;
        end else if (tick) begin
          count_next = sat_dec(count);
          if (count_next == LED_BAR_MIN) state_next = SWEEP_UP;
        end
      end
      default: state_next = MANUAL;
    endcase
  end

  always_comb begin
    current_count = count;
    at_max        = (count == LED_BAR_MAX);
    at_min        = (count == LED_BAR_MIN);
    sweep_dir     = (state == SWEEP_DOWN);
  end

endmodule

// File: tb/tb_led_bar_controller.sv
// Directed bench for led_bar_controller with TICK_DIV = 4.
// Handshake-free design: inputs are levels driven 1 ns after posedge, outputs sampled at the same point.
module tb_led_bar_controller;
  import led_bar_pkg::*;

  localparam int TICK_DIV = 4;
`ifdef LED_BAR_BTN_SYNC_EN
  localparam int SETTLE = 3;
`else
  localparam int SETTLE = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       auto_en = 1'b0;
  logic [4:0] current_count;
  logic       at_max;
  logic       at_min;
  logic       sweep_dir;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  led_bar_controller #(.TICK_DIV(TICK_DIV)) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .auto_en       (auto_en),
    .current_count (current_count),
    .at_max        (at_max),
    .at_min        (at_min),
    .sweep_dir     (sweep_dir)
  );

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic up, input logic down);
    btn_up   = up;
    btn_down = down;
    step(1);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    if (SETTLE > 0) step(SETTLE);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    #1;
    check("rst_count", 32'(current_count), 0);
    check("rst_at_min", 32'(at_min), 1);
    check("rst_at_max", 32'(at_max), 0);
    check("rst_dir", 32'(sweep_dir), 0);
    check("rst_state", 32'(dut.state), 32'(MANUAL));
    step(2);
    rst = 1'b0;
    step(1);

    // manual saturation
    repeat (18) press(1'b1, 1'b0);
    check("sat_count", 32'(current_count), 16);
    check("sat_at_max", 32'(at_max), 1);
    check("sat_at_min", 32'(at_min), 0);
    press(1'b0, 1'b1);
    check("down_15", 32'(current_count), 15);
    check("down_at_max", 32'(at_max), 0);
    press(1'b1, 1'b1);
    check("both_15", 32'(current_count), 15);

`ifdef LED_BAR_BTN_SYNC_EN
    // held button from 3: one step, two edges after the first sampling edge
    repeat (12) press(1'b0, 1'b1);
    check("pre_hold_3", 32'(current_count), 3);
    btn_up = 1'b1;
    step(1);
    check("hold_e0", 32'(current_count), 3);
    step(1);
    check("hold_e1", 32'(current_count), 3);
    step(1);
    check("hold_e2", 32'(current_count), 4);
    step(97);
    check("hold_end", 32'(current_count), 4);
    btn_up = 1'b0;
    step(4);
`else
    // held down from 2: one step per cycle, saturating at 0
    repeat (13) press(1'b0, 1'b1);
    check("pre_hold_2", 32'(current_count), 2);
    btn_down = 1'b1;
    step(1);
    check("hold_1", 32'(current_count), 1);
    step(1);
    check("hold_0", 32'(current_count), 0);
    step(1);
    check("hold_0b", 32'(current_count), 0);
    check("hold_at_min", 32'(at_min), 1);
    btn_down = 1'b0;
    step(1);
`endif

    // bring the level to 14 from a fresh reset
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    repeat (14) press(1'b1, 1'b0);
    check("pre_sweep_14", 32'(current_count), 14);

    // sweep entry and turnaround at the top
    auto_en = 1'b1;
    step(1);
    check("sw_state_up", 32'(dut.state), 32'(SWEEP_UP));
    step(3);
    check("sw_hold_14", 32'(current_count), 14);
    step(1);
    check("sw_15", 32'(current_count), 15);
    step(4);
    check("sw_16", 32'(current_count), 16);
    check("sw_dir_down", 32'(sweep_dir), 1);
    check("sw_at_max", 32'(at_max), 1);
    step(4);
    check("sw_15_down", 32'(current_count), 15);

    // turnaround at the bottom, then one full 128-cycle period
    step(60);
    check("sw_bottom_0", 32'(current_count), 0);
    check("sw_bottom_min", 32'(at_min), 1);
    check("sw_bottom_dir", 32'(sweep_dir), 0);
    step(68);
    check("sw_period_cnt", 32'(current_count), 15);
    check("sw_period_dir", 32'(sweep_dir), 1);

    // asynchronous reset mid-sweep at 9
    step(24);
    check("pre_rst_9", 32'(current_count), 9);
    rst = 1'b1;
    #1;
    check("arst_count", 32'(current_count), 0);
    check("arst_at_min", 32'(at_min), 1);
    check("arst_dir", 32'(sweep_dir), 0);
    check("arst_state", 32'(dut.state), 32'(MANUAL));
    auto_en = 1'b0;
    step(1);
    rst = 1'b0;
    step(1);

    // mode exit on a tick cycle at 7
    auto_en = 1'b1;
    step(1);
    step(28);
    check("exit_pre_7", 32'(current_count), 7);
    step(3);
    check("exit_tick", 32'(dut.u_tick.tick), 1);
    auto_en = 1'b0;
    step(1);
    check("exit_hold_7", 32'(current_count), 7);
    check("exit_state", 32'(dut.state), 32'(MANUAL));
    check("exit_tick_cnt", 32'(dut.u_tick.cnt), 0);

    // re-enable: first step exactly TICK_DIV cycles after entry
    auto_en = 1'b1;
    step(1);
    step(3);
    check("reen_hold_7", 32'(current_count), 7);
    step(1);
    check("reen_8", 32'(current_count), 8);
    auto_en = 1'b0;
    step(2);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_bar_controller.md
# led_bar_controller

Sequencer for the 16-LED thermometer bar. It produces the 5-bit `current_count` (range 0..16) that feeds the LED bar decoder. It supports two modes: manual step up/down from push-buttons, and an automatic ping-pong sweep paced by an internal prescaler. It sits between the board buttons/switches and the decoder; the decoder stays purely combinational.

## Interface
Parameters:
- `TICK_DIV`, default 50_000_000: clock cycles per automatic sweep step; legal range ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `btn_up`  in  1  step-up request.
- `btn_down`  in  1  step-down request.
- `auto_en`  in  1  level: 1 selects sweep mode, 0 selects manual mode.
- `current_count`  out  5  bar level 0..16, to the decoder.
- `at_max`  out  1  high when `current_count` == 16.
- `at_min`  out  1  high when `current_count` == 0.
- `sweep_dir`  out  1  1 while in `SWEEP_DOWN`, else 0.

## Operation
- FSM states: `MANUAL`, `SWEEP_UP`, `SWEEP_DOWN`.
- Reset values: state `MANUAL`, `current_count` = 0, tick counter = 0, `at_min` = 1, `at_max` = 0, `sweep_dir` = 0.
- `at_min`, `at_max` and `sweep_dir` are combinational decodes of registered state/count. They are glitch-free relative to `clk`.
- `MANUAL` mode:
  - Up event → count + 1, saturating at 16.
  - Down event → count − 1, saturating at 0.
  - Up and down events in the same cycle → no change.
- `MANUAL` → `SWEEP_UP` when `auto_en` = 1 and count < 16.
- `MANUAL` → `SWEEP_DOWN` when `auto_en` = 1 and count = 16.
- Sweep states, on each tick:
  - `SWEEP_UP`: count + 1. If the new count is 16, go to `SWEEP_DOWN`.
  - `SWEEP_DOWN`: count − 1. If the new count is 0, go to `SWEEP_UP`.
  - Result: 0→16→0 ping-pong with no repeated endpoint values.
- Button events are ignored in sweep states (but still consumed by edge detection).
- `auto_en` = 0 in any sweep state → `MANUAL` on the next edge. Count is held; no step on that edge even if a tick coincides.
- Tick counter:
  - Width `$clog2(TICK_DIV)`.
  - Held at 0 in `MANUAL`.
  - In sweep states it increments each cycle. At `TICK_DIV`−1 it asserts the tick and wraps to 0.
- All arithmetic is unsigned, 5-bit. Values 17..31 are unreachable. If forced, the next step or event treats them as saturated at 16.

## Timing
- Sweep latency: the first step occurs exactly `TICK_DIV` cycles after the edge on which the state entered a sweep state. Subsequent steps follow every `TICK_DIV` cycles.
- A full sweep period (0→16→0) is 32·`TICK_DIV` cycles.
- Manual latency (macro defined): a button rising before edge N updates the count at edge N+2. The path is 2-flop synchronizer then rising-edge detect.
- Manual latency (macro undefined): the count updates on the edge that samples the button high.
- Mode-change latency: state change 1 cycle after the `auto_en` transition, measured on the raw input. `auto_en` is not synchronized (it is a slide switch, assumed quasi-static).
- Reset mid-operation: outputs return to reset values immediately, asynchronously. Operation resumes in `MANUAL` on the first edge after `rst` falls.

## Configuration
- `LED_BAR_BTN_SYNC_EN` defined:
  - `btn_up`/`btn_down` each pass through a 2-flop synchronizer and a rising-edge detector.
  - One event per press; holding a button gives exactly one step.
- Undefined:
  - Buttons are treated as already-synchronous, single-cycle pulses.
  - Every cycle a button is high is one event; holding steps once per cycle.

## Structure
- Shared package `led_bar_pkg`:
  - state enum `led_bar_state_t` (`MANUAL`, `SWEEP_UP`, `SWEEP_DOWN`);
  - `LED_BAR_MAX` = 5'd16;
  - `LED_BAR_MIN` = 5'd0.
- Sub-module `tick_gen`:
  - parameter `TICK_DIV`;
  - inputs `clk`, `rst`, `enable`;
  - output `tick`;
  - counter clears when `enable` = 0.
- Synchronizer/edge-detect logic stays inline under the macro.

## Test plan
- Reset: assert `rst` mid-sweep at count 9 → immediately `current_count` = 0, `at_min` = 1, `sweep_dir` = 0, state `MANUAL`.
- Manual saturation (macro defined): 18 separate up presses → count 16, `at_max` = 1. Then 1 down press → 15. Press both simultaneously → stays 15.
- Held button (macro defined): hold `btn_up` for 100 cycles from count 3 → count 4, updated exactly 2 edges after the first sampling edge.
- Sweep (`TICK_DIV` = 4): `auto_en` = 1 at count 14 → 15 after 4 cycles, 16 after 8 (`sweep_dir` becomes 1), 15 after 12. Full period 128 cycles.
- Mode exit (`TICK_DIV` = 4): drop `auto_en` on a tick cycle at count 7 → count holds 7, state `MANUAL`, tick counter 0. Re-enable → first step 4 cycles later.
- Macro undefined: `btn_down` high for 3 cycles from count 2 → counts 1, 0, 0, with `at_min` = 1.
